// File: rtl/tpu_pkg.sv
// Shared TPU definitions: weight memory geometry and the loader state encoding.
package tpu_pkg;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 13;
    localparam int WMEM_DEPTH = 256;
    localparam int CNT_W      = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FIN  = 2'd2
    } loader_state_t;

endpackage

// File: rtl/weight_loader.sv
// Weight loader: takes a host stream of weights over valid/ready and writes
// them to consecutive weight memory words starting at a commanded base.
//
// state | meaning
// IDLE  | waiting for start; range-checks the command
// LOAD  | accepting host words, one memory write per transfer
// FIN   | one cycle, done pulse (coincides with the last write)
module weight_loader #(
    parameter int DATA_W = tpu_pkg::DATA_W,
    parameter int ADDR_W = tpu_pkg::ADDR_W,
    parameter int DEPTH  = tpu_pkg::WMEM_DEPTH,
    parameter int CNT_W  = tpu_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);
    import tpu_pkg::*;

    // One bit wider than the widest operand so base+num never wraps.
    localparam int CHK_W = ((ADDR_W > CNT_W) ? ADDR_W : CNT_W) + 1;

    loader_state_t     state;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  num_q;
    logic [CNT_W-1:0]  idx_q;

    logic [CHK_W-1:0]  end_addr;
    logic              range_bad;
    logic              xfer;
    logic              last_xfer;

    // Command range check and handshake decode.
    always_comb begin
        end_addr  = CHK_W'(base_addr) + CHK_W'(num_words);
        range_bad = (end_addr > CHK_W'(DEPTH));
        xfer      = in_valid && in_ready;
        last_xfer = (idx_q == (num_q - CNT_W'(1)));
    end

    // Ready is taken straight from the state register.
    assign in_ready = (state == LOAD);

    // Sequencer FSM with registered write port and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            base_q  <= '0;
            num_q   <= '0;
            idx_q   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_words == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                            busy  <= 1'b1;
                        end else if (range_bad) begin
                            err <= 1'b1;
                        end else begin
                            base_q <= base_addr;
                            num_q  <= num_words;
                            idx_q  <= '0;
                            state  <= LOAD;
                            busy   <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        wr_en   <= 1'b1;
                        wr_addr <= base_q + ADDR_W'(idx_q);
                        wr_data <= in_data;
                        idx_q   <= idx_q + CNT_W'(1);
                        if (last_xfer) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader: expected writes are queued at each
// handshake and compared when the memory write strobe appears.
module tb_weight_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [12:0] base_addr;
    logic [8:0]  num_words;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct packed {
        logic [12:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  fixed_data [0:3] = '{3, 5, 4, 6};

    weight_loader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Write monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wr", 32'(wr_en), 32'(0));
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                chk("wr_data", 32'(wr_data), 32'(e.data));
            end
        end
    end

    task automatic do_start(input int base, input int n);
        start     = 1'b1;
        base_addr = 13'(base);
        num_words = 9'(n);
        tick;
        start = 1'b0;
    endtask

    // Streams n words into an already started command; start_at < 0 means no
    // stray start pulse during LOAD.
    task automatic load_words(input int base, input int n, input bit gaps,
                              input bit fixed, input int start_at);
        int  idx = 0;
        int  cyc = 0;
        bit  v;
        bit  x;
        wr_t e;
        while (idx < n && cyc < 200) begin
            v        = gaps ? (cyc % 2 == 0) : 1'b1;
            in_valid = v;
            in_data  = fixed ? 16'(fixed_data[idx % 4]) : 16'($urandom_range(0, 65535));
            if (cyc == start_at) begin
                start     = 1'b1;
                base_addr = 13'd100;
                num_words = 9'd4;
            end
            x = v && in_ready;
            if (x) begin
                e.addr = 13'(base + idx);
                e.data = in_data;
                exp_q.push_back(e);
                idx++;
            end
            tick;
            start = 1'b0;
            cyc++;
            chk("wr_en_lat", 32'(wr_en), 32'(x));
            chk("done", 32'(done), 32'(idx == n));
            chk("in_ready", 32'(in_ready), 32'(idx < n));
            chk("busy", 32'(busy), 32'(1));
        end
        in_valid = 1'b0;
        chk("xfer_cnt", 32'(idx), 32'(n));
        tick;
        chk("done_fall", 32'(done), 32'(0));
        chk("busy_fall", 32'(busy), 32'(0));
        chk("wr_en_idle", 32'(wr_en), 32'(0));
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        num_words = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        tick;
        tick;
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        chk("rst_wr_en", 32'(wr_en), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_wr_addr", 32'(wr_addr), 32'(0));
        chk("rst_wr_data", 32'(wr_data), 32'(0));
        rst = 1'b0;
        tick;

        // Back-to-back stream of 3,5,4,6 at base 0.
        do_start(0, 4);
        chk("t1_in_ready", 32'(in_ready), 32'(1));
        chk("t1_busy", 32'(busy), 32'(1));
        load_words(0, 4, 1'b0, 1'b1, -1);

        // Valid toggling 1,0,1,0,1 at base 8.
        do_start(8, 3);
        load_words(8, 3, 1'b1, 1'b0, -1);

        // Out-of-range command is rejected with a one-cycle err.
        do_start(254, 3);
        chk("t3_err", 32'(err), 32'(1));
        chk("t3_busy", 32'(busy), 32'(0));
        chk("t3_in_ready", 32'(in_ready), 32'(0));
        tick;
        chk("t3_err_fall", 32'(err), 32'(0));
        chk("t3_busy2", 32'(busy), 32'(0));

        // Exactly fills the top of memory.
        do_start(253, 3);
        chk("t3b_err", 32'(err), 32'(0));
        load_words(253, 3, 1'b0, 1'b0, -1);

        // Zero-count command: done one cycle after start, no writes.
        do_start(5, 0);
        chk("t4_done", 32'(done), 32'(1));
        chk("t4_busy", 32'(busy), 32'(1));
        chk("t4_in_ready", 32'(in_ready), 32'(0));
        tick;
        chk("t4_done_fall", 32'(done), 32'(0));
        chk("t4_busy_fall", 32'(busy), 32'(0));
        chk("t4_in_ready2", 32'(in_ready), 32'(0));

        // Stray start during LOAD must not disturb the addresses.
        do_start(40, 4);
        load_words(40, 4, 1'b0, 1'b0, 1);

        // Reset after 2 of 4 words aborts the command.
        do_start(20, 4);
        for (int i = 0; i < 2; i++) begin
            wr_t e;
            in_valid = 1'b1;
            in_data  = 16'($urandom_range(0, 65535));
            chk("t6_in_ready", 32'(in_ready), 32'(1));
            e.addr = 13'(20 + i);
            e.data = in_data;
            exp_q.push_back(e);
            tick;
        end
        rst = 1'b1;
        tick;
        chk("t6_rst_wr_en", 32'(wr_en), 32'(0));
        chk("t6_rst_busy", 32'(busy), 32'(0));
        chk("t6_rst_done", 32'(done), 32'(0));
        chk("t6_rst_in_ready", 32'(in_ready), 32'(0));
        chk("t6_rst_wr_addr", 32'(wr_addr), 32'(0));
        chk("t6_rst_wr_data", 32'(wr_data), 32'(0));
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("t6_no_done", 32'(done), 32'(0));
            chk("t6_no_ready", 32'(in_ready), 32'(0));
        end
        in_valid = 1'b0;
        do_start(60, 4);
        chk("t6_restart_ready", 32'(in_ready), 32'(1));
        load_words(60, 4, 1'b0, 1'b0, -1);

        tick;
        tick;
        chk("sb_empty", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
